// File: rtl/ad_frontend.sv
// ADC front end: derives ad_clk from sys_clk, captures and clamps samples, removes
// the DC offset with a block-averaged estimate and raises a held over-range flag.
module ad_frontend #(
    parameter int CLK_DIV  = 2,
    parameter int AVG_LOG2 = 10,
    parameter int OTR_HOLD = 1024
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] ad_data,
    input  logic       ad_otr,
    output logic       ad_clk,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic [7:0] dc_est,
    output logic       dc_ready,
    output logic       otr_flag
);
    localparam int DW     = $clog2(CLK_DIV);
    localparam int AW     = 8 + AVG_LOG2;
    localparam int HW     = $clog2(OTR_HOLD + 1);
    localparam int STAGES = 2;

    typedef enum logic {WARMUP, TRACK} dc_state_t;

    logic [DW-1:0]       r_div_cnt;
    logic [DW-1:0]       w_div_nxt;
    logic                w_div_last;
    logic [7:0]          r_raw;
    logic                r_otr;
    logic [STAGES:0]     r_vld_pipe;
    logic [7:0]          w_clamped;
    logic signed [8:0]   w_diff;
    logic [7:0]          w_diff_sat;
    logic [7:0]          r_diff;
    dc_state_t           r_state;
    logic [AW-1:0]       r_acc;
    logic [AW-1:0]       w_acc_sum;
    logic [AVG_LOG2-1:0] r_cnt;
    logic                w_blk_end;
    logic [HW-1:0]       r_hold;

    assign w_div_last = (r_div_cnt == DW'(CLK_DIV - 1));
    assign w_div_nxt  = w_div_last ? '0 : r_div_cnt + DW'(1);

    // ad_clk tracks the divider phase it is about to enter, so it rises CLK_DIV/2 after reset
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_div_cnt  <= '0;
            ad_clk     <= 1'b0;
            r_raw      <= '0;
            r_otr      <= 1'b0;
            r_vld_pipe <= '0;
        end else begin
            r_div_cnt  <= w_div_nxt;
            ad_clk     <= (w_div_nxt >= DW'(CLK_DIV / 2));
            r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_div_last};
            if (w_div_last) begin
                r_raw <= ad_data;
                r_otr <= ad_otr;
            end
        end
    end

    assign sample_valid = r_vld_pipe[STAGES];
    assign w_clamped    = r_otr ? {8{r_raw[7]}} : r_raw;
    assign w_diff       = $signed({1'b0, w_clamped}) - $signed({1'b0, dc_est});
    assign w_diff_sat   = (w_diff[8] == w_diff[7]) ? w_diff[7:0] : (w_diff[8] ? 8'h80 : 8'h7F);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_diff <= '0;
            sample <= '0;
        end else begin
            if (r_vld_pipe[0]) r_diff <= w_diff_sat;
            if (r_vld_pipe[1]) sample <= r_diff;
        end
    end

    assign w_acc_sum = r_acc + AW'(w_clamped);
    assign w_blk_end = &r_cnt;

    // the block-ending sample is folded into the sum that produces the new estimate
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= WARMUP;
            r_acc    <= '0;
            r_cnt    <= '0;
            dc_est   <= 8'd128;
            dc_ready <= 1'b0;
        end else if (r_vld_pipe[0]) begin
            if (w_blk_end) begin
                r_acc  <= '0;
                r_cnt  <= '0;
                dc_est <= w_acc_sum[AW-1:AVG_LOG2];
            end else begin
                r_acc <= w_acc_sum;
                r_cnt <= r_cnt + AVG_LOG2'(1);
            end
            case (r_state)
                WARMUP: begin
                    if (w_blk_end) begin
                        dc_ready <= 1'b1;
                        r_state  <= TRACK;
                    end
                end
                TRACK:   dc_ready <= 1'b1;
                default: r_state  <= WARMUP;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_hold   <= '0;
            otr_flag <= 1'b0;
        end else if (r_vld_pipe[0]) begin
            if (r_otr) begin
                r_hold   <= HW'(OTR_HOLD);
                otr_flag <= 1'b1;
            end else if (r_hold != '0) begin
                r_hold   <= r_hold - HW'(1);
                otr_flag <= (r_hold != HW'(1));
            end
        end
    end
endmodule
